bus_grant_arbiter: RTL and testbench
====================================

Name: bus_grant_arbiter

Overview:
- Round-robin arbiter that shares the 32-source internal CPU bus between register/unit "out" requesters.
- Produces a registered one-hot grant, which drives the bus encoder, and a matching 5-bit bus select.
- Enforces a bounded ownership time and a one-cycle turnaround between owners so that two sources never drive the bus in the same cycle.

Parameters:
- N_REQ, 32, number of requesters; fixed at 32 to match the 5-bit bus select; other values unsupported.
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant before forced release; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  reset; synchronous, active-high.
- req  input  32  per-source bus request; level-sensitive.
- release  input  1  current owner ends its transfer this cycle.
- gnt  output  32  registered one-hot grant; all-zero when bus idle.
- bus_sel  output  5  binary index of the granted source; 0 when idle.
- bus_busy  output  1  high while any grant is active; disambiguates source 0 from idle.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (clr=1 at a clock edge): gnt=0, bus_sel=0, bus_busy=0, timeout=0, state=IDLE, rr_ptr=0, hold_cnt=0. This takes effect regardless of state, including mid-ownership. No grant is issued in the cycle clr is high.
- States:
  - IDLE: no owner.
  - OWN: one owner holds the grant.
- IDLE -> OWN:
  - If req != 0, choose the lowest index i that is >= rr_ptr and has req[i]=1. If none qualifies, wrap and choose the lowest index < rr_ptr with req[i]=1.
  - On the next edge: gnt = 1<<i, bus_sel = i, bus_busy=1, hold_cnt=1, rr_ptr = (i+1) mod 32 (wraps 31 -> 0).
  - Latency from req sampled high to gnt high is 1 cycle.
- OWN: owner index and gnt are frozen, and non-owner req changes are ignored. Each edge evaluates exit conditions in this priority:
  - (a) release=1 or req[owner]=0: go to IDLE, no timeout pulse.
  - (b) hold_cnt == MAX_HOLD: go to IDLE, timeout=1 for exactly one cycle, aligned with the cycle gnt drops to 0.
  - (c) otherwise: hold_cnt increments and saturates at 15.
- OWN -> IDLE: gnt=0, bus_sel=0, bus_busy=0 for at least one full cycle (turnaround bubble). There is no direct owner-to-owner handoff, so back-to-back owners see gnt high, 1 cycle low, gnt high.
- Simultaneous events:
  - release together with hold limit: release wins, no timeout.
  - All 32 requesting: round-robin order is strictly ascending from rr_ptr.
  - req deasserted in the same cycle it would be granted in IDLE: the arbiter uses the value sampled at that edge only.
- Invariants: gnt is always zero or one-hot; bus_sel == index of gnt's set bit; bus_busy == |gnt.
- Outputs are registered only; there is no combinational path from req to gnt.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - Adds input port `lock` (1 bit).
  - While in OWN with lock=1, exit condition (b) is suppressed: hold_cnt saturates and no timeout occurs, so the owner keeps the bus until release or req drop.
  - lock is ignored in IDLE.
  - When lock falls with hold_cnt >= MAX_HOLD, the timeout exit occurs at the next edge.
- Undefined: no `lock` port; MAX_HOLD always enforced.

Test Plan:
- clr=1 for 2 cycles with req=32'hFFFF_FFFF: gnt=0, bus_busy=0, bus_sel=0. One cycle after clr drops: gnt=32'h0000_0001, bus_sel=0, bus_busy=1.
- req=32'h0000_0110 constant, release pulsed 1 cycle after each grant: grants alternate source 4, bubble, source 8, bubble, source 4, with bus_sel 4/0/8/0/4.
- req[31]=1 only, held, MAX_HOLD=4: gnt=32'h8000_0000 for 4 cycles, then gnt=0 with timeout=1 for 1 cycle, then gnt=32'h8000_0000 again. rr_ptr wrapped to 0 and no other requester exists.
- Owner source 5 at hold_cnt=4 with release=1 in the same cycle: gnt drops, timeout stays 0.
- clr asserted while source 12 owns the bus: next cycle gnt=0 and rr_ptr=0. With req=32'h0000_1001 afterwards, source 0 is granted first.
- ARB_LOCK_EN defined, source 3 owning with lock=1 for 10 cycles and MAX_HOLD=4: gnt held for all 10 cycles with no timeout. Lock deasserted with req held: next edge gnt=0 and timeout=1.

Source files
------------

// File: rtl/bus_grant_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_grant_arbiter: round-robin owner arbiter for the 32-source CPU bus with
// bounded hold time and a one-cycle idle bubble between owners.
// Optional macro ARB_LOCK_EN adds a `lock` input that suspends the hold limit.
// Revision: 1.0
// ----------------------------------------------------------------------------
module bus_grant_arbiter #(
  parameter int N_REQ    = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_REQ-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  // `release` is a reserved word, hence the longer name
  input  logic             owner_release,
  output logic [N_REQ-1:0] gnt,
  output logic [4:0]       bus_sel,
  output logic             bus_busy,
  output logic             timeout
);

  typedef enum logic [0:0] {IDLE = 1'b0, OWN = 1'b1} state_t;

  localparam logic [3:0] C_MAX_HOLD = 4'(MAX_HOLD);

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   gnt_nxt;
  logic [4:0]         sel_nxt;
  logic               busy_nxt;
  logic               timeout_nxt;
  logic [4:0]         rr_ptr, ptr_nxt;
  logic [3:0]         hold_cnt, hold_nxt;
  logic               found;
  logic [4:0]         pick;
  logic [4:0]         idx;
  logic               lock_on;

`ifdef ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  // First requester in ascending order starting at rr_ptr, wrapping at 31.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    idx   = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_ptr + 5'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    sel_nxt     = bus_sel;
    busy_nxt    = bus_busy;
    timeout_nxt = 1'b0;
    ptr_nxt     = rr_ptr;
    hold_nxt    = hold_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = OWN;
          gnt_nxt       = '0;
          gnt_nxt[pick] = 1'b1;
          sel_nxt       = pick;
          busy_nxt      = 1'b1;
          hold_nxt      = 4'd1;
          ptr_nxt       = pick + 5'd1;
        end
      end
      OWN: begin
        // Voluntary exit outranks the hold limit, so no timeout on release.
        if (owner_release || !req[bus_sel]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          sel_nxt   = 5'd0;
          busy_nxt  = 1'b0;
          hold_nxt  = 4'd0;
        end else if (!lock_on && (hold_cnt >= C_MAX_HOLD)) begin
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          sel_nxt     = 5'd0;
          busy_nxt    = 1'b0;
          hold_nxt    = 4'd0;
          timeout_nxt = 1'b1;
        end else if (hold_cnt != 4'd15) begin
          hold_nxt = hold_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        sel_nxt   = 5'd0;
        busy_nxt  = 1'b0;
        hold_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      gnt      <= '0;
      bus_sel  <= 5'd0;
      bus_busy <= 1'b0;
      timeout  <= 1'b0;
      rr_ptr   <= 5'd0;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      bus_sel  <= sel_nxt;
      bus_busy <= busy_nxt;
      timeout  <= timeout_nxt;
      rr_ptr   <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_grant_arbiter.sv
`default_nettype none
// Bench for bus_grant_arbiter: directed vectors, a per-cycle reference model
// and hand-computed literal checks.
module tb_bus_grant_arbiter;

  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] req;
  logic        owner_release;
`ifdef ARB_LOCK_EN
  logic        lock;
`endif
  logic [31:0] gnt;
  logic [4:0]  bus_sel;
  logic        bus_busy;
  logic        timeout;

  always #5 clk = ~clk;

  bus_grant_arbiter #(.N_REQ(32), .MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .clr          (clr),
    .req          (req),
`ifdef ARB_LOCK_EN
    .lock         (lock),
`endif
    .owner_release(owner_release),
    .gnt          (gnt),
    .bus_sel      (bus_sel),
    .bus_busy     (bus_busy),
    .timeout      (timeout)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference model: owner index (-1 when idle), pointer and hold count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;
  bit m_valid = 1'b0;

  function automatic int rr_pick(input logic [31:0] r, input int ptr);
    for (int k = 0; k < 32; k++)
      if (r[(ptr + k) % 32]) return (ptr + k) % 32;
    return -1;
  endfunction

  function automatic bit lock_now();
`ifdef ARB_LOCK_EN
    return lock;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0; m_valid = 1'b1;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      m_owner = rr_pick(req, m_ptr);
      if (m_owner >= 0) begin
        m_hold = 1;
        m_ptr  = (m_owner + 1) % 32;
      end
    end else begin
      m_to = 1'b0;
      if (owner_release || !req[m_owner]) begin
        m_owner = -1;
      end else if (m_hold >= MAX_HOLD && !lock_now()) begin
        m_owner = -1;
        m_to    = 1'b1;
      end else if (m_hold < 15) begin
        m_hold++;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] one;
    one = 32'd1;
    if (m_valid) begin
      chk("model_gnt",     gnt,             (m_owner >= 0) ? (one << m_owner) : 32'd0);
      chk("model_bus_sel", {27'd0, bus_sel}, (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk("model_busy",    {31'd0, bus_busy}, {31'd0, m_owner >= 0});
      chk("model_timeout", {31'd0, timeout},  {31'd0, m_to});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b1; req = 32'hFFFF_FFFF; owner_release = 1'b0;
`ifdef ARB_LOCK_EN
    lock = 1'b0;
`endif
    // Reset with everyone requesting, then source 0 first.
    tick(); tick();
    chk("rst_gnt", gnt, 32'h0);
    chk("rst_busy", {31'd0, bus_busy}, 32'd0);
    chk("rst_sel", {27'd0, bus_sel}, 32'd0);
    clr = 1'b0;
    tick();
    chk("first_gnt", gnt, 32'h0000_0001);
    chk("first_busy", {31'd0, bus_busy}, 32'd1);

    // Alternation between sources 4 and 8 with a bubble between.
    clr = 1'b1; tick(); clr = 1'b0; req = 32'h0000_0110;
    tick(); chk("alt_g4a", gnt, 32'h0000_0010); chk("alt_s4a", {27'd0, bus_sel}, 32'd4);
    owner_release = 1'b1;
    tick(); chk("alt_bub1", gnt, 32'h0); chk("alt_bsel1", {27'd0, bus_sel}, 32'd0);
    owner_release = 1'b0;
    tick(); chk("alt_g8", gnt, 32'h0000_0100); chk("alt_s8", {27'd0, bus_sel}, 32'd8);
    owner_release = 1'b1;
    tick(); chk("alt_bub2", gnt, 32'h0);
    owner_release = 1'b0;
    tick(); chk("alt_g4b", gnt, 32'h0000_0010); chk("alt_s4b", {27'd0, bus_sel}, 32'd4);

    // Source 31 alone: hold limit, timeout pulse, regrant after wrap.
    clr = 1'b1; tick(); clr = 1'b0; req = 32'h8000_0000;
    for (int c = 0; c < 4; c++) begin
      tick(); chk("hold31_gnt", gnt, 32'h8000_0000); chk("hold31_to", {31'd0, timeout}, 32'd0);
    end
    tick(); chk("to31_gnt", gnt, 32'h0); chk("to31_pulse", {31'd0, timeout}, 32'd1);
    tick(); chk("re31_gnt", gnt, 32'h8000_0000); chk("re31_to", {31'd0, timeout}, 32'd0);

    // Release coincides with hold limit: no timeout.
    clr = 1'b1; tick(); clr = 1'b0; req = 32'h0000_0020;
    tick(); tick(); tick(); tick();
    chk("s5_held", gnt, 32'h0000_0020);
    owner_release = 1'b1;
    tick(); chk("s5_drop", gnt, 32'h0); chk("s5_no_to", {31'd0, timeout}, 32'd0);
    owner_release = 1'b0;

    // Reset mid-ownership clears the pointer: source 0 beats source 13.
    req = 32'h0000_1000; tick();
    chk("s12_gnt", gnt, 32'h0000_1000);
    clr = 1'b1; tick(); chk("s12_clr", gnt, 32'h0);
    clr = 1'b0; req = 32'h0000_2001;
    tick(); chk("ptr_reset", gnt, 32'h0000_0001);

    // All 32 requesting, release each grant: ascending sweep checked by model.
    clr = 1'b1; tick(); clr = 1'b0; req = 32'hFFFF_FFFF;
    for (int c = 0; c < 70; c++) begin
      owner_release = c[0];
      tick();
    end
    owner_release = 1'b0;

    // Requests toggling under an owner and a dropped owner request.
    clr = 1'b1; tick(); clr = 1'b0; req = 32'h0000_0C00;
    for (int c = 0; c < 20; c++) begin
      req = (c % 5 == 3) ? 32'h0000_0400 : 32'h0000_0C00 ^ {22'd0, c[0], 9'd0};
      tick();
    end

`ifdef ARB_LOCK_EN
    // Lock suspends the hold limit; dropping it times out at the next edge.
    clr = 1'b1; tick(); clr = 1'b0; req = 32'h0000_0008; lock = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(); chk("lock_gnt", gnt, 32'h0000_0008); chk("lock_no_to", {31'd0, timeout}, 32'd0);
    end
    lock = 1'b0;
    tick(); chk("unlock_gnt", gnt, 32'h0); chk("unlock_to", {31'd0, timeout}, 32'd1);
`endif

    req = 32'h0;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
